rw_read_data: RTL and testbench

RW_READ_DATA -- requirements
Module: rw_read_data

---
 rtl/rw_read_data_pkg.sv | 29 ++
 rtl/rw_read_data_cmd_latch.sv | 58 +++++
 rtl/rw_read_data.sv | 65 ++++++
 tb/tb_rw_read_data.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rw_read_data_pkg.sv
// Shared definitions for the read/write command latch and the storage it drives.
// Holds the rw encodings, the default PCI memory command codes and the FSM state type.
package rw_read_data_pkg;

    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    localparam logic [3:0] DEFAULT_READ_CMD  = 4'b0110;
    localparam logic [3:0] DEFAULT_WRITE_CMD = 4'b0111;

    typedef enum logic {
        StIdle,
        StXfer
    } state_e;

    // Map an address-phase C/BE# code onto the rw encoding; unknown codes give RW_NONE.
    function automatic logic [1:0] decode_cmd(input logic [3:0] cbe,
                                              input logic [3:0] read_cmd,
                                              input logic [3:0] write_cmd);
        if (cbe == read_cmd) begin
            return RW_READ;
        end else if (cbe == write_cmd) begin
            return RW_WRITE;
        end
        return RW_NONE;
    endfunction

endpackage

// File: rtl/rw_read_data_cmd_latch.sv
// Transaction FSM: samples the command on the address phase and holds the
// transaction type until the bus returns to idle.
module rw_cmd_latch
    import rw_read_data_pkg::*;
#(
    parameter logic [3:0] READ_CMD  = DEFAULT_READ_CMD,
    parameter logic [3:0] WRITE_CMD = DEFAULT_WRITE_CMD
) (
    input  logic       Clock,
    input  logic       RST,
    input  logic       Frame,
    input  logic [3:0] CBE,
    input  logic       Irdy,
    output logic [1:0] rw,
    output logic       xfer
);

    state_e     state_q, state_d;
    logic [1:0] rw_q, rw_d;

    always_ff @(posedge Clock) begin
        if (!RST) begin
            state_q <= StIdle;
            rw_q    <= RW_NONE;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        unique case (state_q)
            StIdle: begin
                if (!Frame) begin
                    state_d = StXfer;
                    rw_d    = decode_cmd(CBE, READ_CMD, WRITE_CMD);
                end
            end
            StXfer: begin
                // Both FRAME# and IRDY# deasserted: bus idle, transaction over.
                if (Frame && Irdy) begin
                    state_d = StIdle;
                    rw_d    = RW_NONE;
                end
            end
            default: begin
                state_d = StIdle;
                rw_d    = RW_NONE;
            end
        endcase
    end

    assign rw   = rw_q;
    assign xfer = (state_q == StXfer);

endmodule

// File: rtl/rw_read_data.sv
// PCI target read/write decode: latches the transaction type, generates storage
// enables for each completed data beat and counts the beats.
module rw_read_data
    import rw_read_data_pkg::*;
#(
    parameter logic [3:0]  READ_CMD  = DEFAULT_READ_CMD,
    parameter logic [3:0]  WRITE_CMD = DEFAULT_WRITE_CMD,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             Clock,
    input  logic             RST,
    input  logic             Frame,
    input  logic [3:0]       CBE,
    input  logic             Irdy,
    input  logic             Devsel,
    output logic [1:0]       rw,
    output logic             RE,
    output logic             WE,
    output logic [CNT_W-1:0] beats
);

    logic             xfer;
    logic             xfer_end;
    logic             beat;
    logic [CNT_W-1:0] beats_q, beats_d;

    rw_cmd_latch #(
        .READ_CMD (READ_CMD),
        .WRITE_CMD(WRITE_CMD)
    ) u_cmd_latch (
        .Clock(Clock),
        .RST  (RST),
        .Frame(Frame),
        .CBE  (CBE),
        .Irdy (Irdy),
        .rw   (rw),
        .xfer (xfer)
    );

    // A data beat completes when both initiator and target are ready.
    assign RE       = xfer && (rw == RW_READ)  && !Devsel && !Irdy;
    assign WE       = xfer && (rw == RW_WRITE) && !Devsel && !Irdy;
    assign beat     = RE || WE;
    assign xfer_end = xfer && Frame && Irdy;

    always_comb begin
        beats_d = beats_q;
        if (xfer_end) begin
            beats_d = '0;
        end else if (beat && (beats_q != {CNT_W{1'b1}})) begin
            beats_d = beats_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!RST) begin
            beats_q <= '0;
        end else begin
            beats_q <= beats_d;
        end
    end

    assign beats = beats_q;

endmodule

// File: tb/tb_rw_read_data.sv
// Directed bench for rw_read_data: inputs change on the falling edge, enables are
// checked just before the rising edge, registered outputs just after it.
module tb_rw_read_data;

    logic       Clock = 1'b0;
    logic       RST;
    logic       Frame;
    logic [3:0] CBE;
    logic       Irdy;
    logic       Devsel;
    logic [1:0] rw;
    logic       RE;
    logic       WE;
    logic [7:0] beats;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clock = ~Clock;

    rw_read_data #(
        .READ_CMD (4'b0110),
        .WRITE_CMD(4'b0111),
        .CNT_W    (8)
    ) dut (
        .Clock (Clock),
        .RST   (RST),
        .Frame (Frame),
        .CBE   (CBE),
        .Irdy  (Irdy),
        .Devsel(Devsel),
        .rw    (rw),
        .RE    (RE),
        .WE    (WE),
        .beats (beats)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply bus inputs after the falling edge and let combinational outputs settle.
    task automatic drive(input logic f, input logic [3:0] c, input logic i, input logic d);
        @(negedge Clock);
        Frame  = f;
        CBE    = c;
        Irdy   = i;
        Devsel = d;
        #1;
    endtask

    task automatic edge_step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [1:0] erw, input logic [7:0] eb);
        check({tag, ".rw"}, {30'd0, rw}, {30'd0, erw});
        check({tag, ".beats"}, {24'd0, beats}, {24'd0, eb});
    endtask

    initial begin
        RST = 1'b0;
        Frame = 1'b1;
        CBE = 4'hf;
        Irdy = 1'b1;
        Devsel = 1'b1;
        edge_step();
        edge_step();
        check_regs("reset", 2'b00, 8'd0);
        check("reset.RE", {31'd0, RE}, 32'd0);
        check("reset.WE", {31'd0, WE}, 32'd0);
        RST = 1'b1;

        // Write: address phase, 3 data beats with CBE=1111, last phase, idle.
        drive(1'b0, 4'h7, 1'b1, 1'b1);
        check("wr.addr.WE", {31'd0, WE}, 32'd0);
        edge_step();
        check_regs("wr.addr", 2'b10, 8'd0);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 4'hf, 1'b0, 1'b0);
            check("wr.data.WE", {31'd0, WE}, 32'd1);
            check("wr.data.RE", {31'd0, RE}, 32'd0);
            edge_step();
            check_regs("wr.data", 2'b10, 8'(i));
        end
        drive(1'b1, 4'hf, 1'b0, 1'b0);
        check("wr.last.WE", {31'd0, WE}, 32'd1);
        edge_step();
        check_regs("wr.last", 2'b10, 8'd4);
        drive(1'b1, 4'hf, 1'b1, 1'b1);
        check("wr.idle.WE", {31'd0, WE}, 32'd0);
        edge_step();
        check_regs("wr.idle", 2'b00, 8'd0);

        // Read with stalls (Devsel high, then Irdy high) in the middle.
        drive(1'b0, 4'h6, 1'b1, 1'b1);
        edge_step();
        check_regs("rd.addr", 2'b01, 8'd0);
        for (int i = 1; i <= 6; i++) begin
            if (i == 4) begin
                drive(1'b0, 4'h0, 1'b0, 1'b1);
                check("rd.nodevsel.RE", {31'd0, RE}, 32'd0);
                edge_step();
                check_regs("rd.nodevsel", 2'b01, 8'd3);
                drive(1'b0, 4'h0, 1'b1, 1'b0);
                check("rd.noirdy.RE", {31'd0, RE}, 32'd0);
                edge_step();
                check_regs("rd.noirdy", 2'b01, 8'd3);
            end
            drive(1'b0, 4'h0, 1'b0, 1'b0);
            check("rd.data.RE", {31'd0, RE}, 32'd1);
            check("rd.data.WE", {31'd0, WE}, 32'd0);
            edge_step();
            check_regs("rd.data", 2'b01, 8'(i));
        end
        drive(1'b1, 4'h0, 1'b0, 1'b0);
        check("rd.last.RE", {31'd0, RE}, 32'd1);
        edge_step();
        check_regs("rd.last", 2'b01, 8'd7);
        drive(1'b1, 4'hf, 1'b1, 1'b1);
        edge_step();
        check_regs("rd.idle", 2'b00, 8'd0);

        // Unsupported command: stays in transfer, no enables, no beats.
        drive(1'b0, 4'h2, 1'b1, 1'b1);
        edge_step();
        check_regs("bad.addr", 2'b00, 8'd0);
        for (int i = 0; i < 3; i++) begin
            drive((i == 2) ? 1'b1 : 1'b0, 4'h0, 1'b0, 1'b0);
            check("bad.data.RE", {31'd0, RE}, 32'd0);
            check("bad.data.WE", {31'd0, WE}, 32'd0);
            edge_step();
            check_regs("bad.data", 2'b00, 8'd0);
        end
        drive(1'b1, 4'hf, 1'b1, 1'b1);
        edge_step();

        // Long write saturates the beat counter.
        drive(1'b0, 4'h7, 1'b1, 1'b1);
        edge_step();
        for (int i = 0; i < 260; i++) begin
            drive(1'b0, 4'hf, 1'b0, 1'b0);
            edge_step();
        end
        check_regs("sat", 2'b10, 8'hff);
        drive(1'b1, 4'hf, 1'b1, 1'b1);
        edge_step();
        check_regs("sat.idle", 2'b00, 8'd0);

        // Reset mid-write while WE is asserted.
        drive(1'b0, 4'h7, 1'b1, 1'b1);
        edge_step();
        drive(1'b0, 4'hf, 1'b0, 1'b0);
        edge_step();
        check_regs("mid.pre", 2'b10, 8'd1);
        @(negedge Clock);
        RST = 1'b0;
        #1;
        check("mid.WE.before", {31'd0, WE}, 32'd1);
        edge_step();
        check_regs("mid.rst", 2'b00, 8'd0);
        check("mid.WE.after", {31'd0, WE}, 32'd0);
        check("mid.RE.after", {31'd0, RE}, 32'd0);
        @(negedge Clock);
        RST = 1'b1;
        Frame = 1'b1;
        Irdy = 1'b1;
        #1;
        edge_step();
        check_regs("mid.release", 2'b00, 8'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
